spectrum_centroid_extractor: RTL
================================

// Module: spectrum_centroid_extractor
// PURPOSE
//  Sits directly downstream of the sensor acquisition packetiser and consumes its 32-bit AXI-Stream packets.
//  Packet format: HEADER, TIMESTAMP, W0..W2, FOOTER.
//  Validates framing, unpacks the 96-bit {d_acc,c_acc} payload and computes centroid = d_acc/c_acc in fixed point with a sequential divider.
//  Presents one result record per good packet on a valid/ready port for the PS register bank.
// PARAMETERS
//  FRAC_BITS     8             fractional bits of centroid; Q = 10+FRAC_BITS, D = 48+FRAC_BITS
//  HEADER_VALUE  32'hAAAAAAAA  packet start word
//  FOOTER_VALUE  32'h55555555  packet end word
// PORTS
//  master_clock      in   1   single clock, 40 MHz
//  resetn            in   1   asynchronous active-low reset
//  data_tdata        in   32  upstream stream word
//  data_tvalid       in   1   upstream word valid
//  data_tlast        in   1   upstream last-packet-of-batch flag (footer only)
//  data_tready       out  1   block can accept a word
//  result_valid      out  1   result record valid
//  result_ready      in   1   consumer accepts record
//  result_centroid   out  Q   centroid, unsigned Q10.FRAC_BITS
//  result_timestamp  out  32  TIMESTAMP word of the packet
//  result_c_acc      out  48  c_acc of the packet (total energy)
//  result_flags      out  3   {last, saturated, div_zero}
//  frame_err_count   out  16  framing errors, saturating
//  drop_count        out  16  beats with tvalid=1 and tready=0, saturating
//  dbg_state         out  4   FSM state code
// BEHAVIOUR
//  Reset: every output and all counters are 0; FSM goes to HUNT. A partial packet or division in progress is discarded.
//  Beat: tvalid & tready on a rising edge. data_tready = 1 in all states except DIVIDE and HOLD.
//  Payload mapping:
//   W0 = c_acc[31:0]; W1 = {d_acc[15:0], c_acc[47:32]}; W2 = d_acc[47:16].
//  FSM states, codes 0..8: HUNT, TS, W0, W1, W2, FTR, DISCARD, DIVIDE, HOLD.
//   HUNT: beat==HEADER -> TS. Any other beat is ignored and is not an error.
//   TS: any beat latches the timestamp -> W0.
//   W0/W1/W2: a beat latches the payload word -> next state (W2 -> FTR).
//    beat==FOOTER -> error, HUNT; beat==HEADER -> error, TS (resync).
//   FTR: beat==FOOTER latches tlast -> DIVIDE.
//    beat==HEADER -> error, TS; any other beat -> error, DISCARD. Raw-data packets therefore land in DISCARD.
//   DISCARD: beat==FOOTER -> HUNT; beat==HEADER -> TS. Other beats are ignored.
//   Each "error" adds 1 to frame_err_count, saturating at 16'hFFFF.
//  DIVIDE: restoring division of (d_acc << FRAC_BITS) by c_acc.
//   One quotient bit per cycle, D iterations.
//   Takes D edges after the footer edge, then -> HOLD with result_valid=1.
//   c_acc==0: skip division; next edge -> HOLD with centroid=0 and div_zero=1.
//   Internal quotient is D bits. Any bit >= Q set -> centroid = all-ones, saturated=1.
//  HOLD: result_* outputs are stable while result_valid=1.
//   result_valid & result_ready -> result_valid=0 and HUNT on the same edge.
//   result_ready is a don't-care when result_valid=0.
//  drop_count: +1 on every edge with tvalid=1 and tready=0 (DIVIDE/HOLD), saturating. Dropped words are lost.
//  Upstream has no backpressure; the sensor line period leaves >=1000 idle cycles between packets.
//  result_* outputs keep their last value after the handshake until the next packet's division finishes.
// TESTING
//  1. c_acc=4, d_acc=12, ts=0x1234: AAAAAAAA,1234,4,000C0000,0,55555555 -> after 56 edges centroid=0x00300, ts=0x1234, flags=0.
//  2. c_acc=3, d_acc=1 -> centroid=0x00055 (85/256); c_acc=1, d_acc=2^40 -> centroid=0x3FFFF, saturated=1.
//  3. W0=W1=W2=0 -> on the edge after the footer, result_valid=1, centroid=0, div_zero=1.
//  4. Footer in W1 slot -> frame_err_count=1, no result; next good packet decodes correctly.
//   Raw packet with 6 index words then FOOTER -> frame_err_count +1, state back to HUNT.
//  5. Hold result_ready=0 for 200 cycles and inject 3 beats in HOLD -> record stable, drop_count=3.
//   Then result_ready=1 -> one handshake, FSM returns to HUNT.
//  6. Deassert resetn 20 cycles into DIVIDE -> all outputs 0 immediately with no clock edge.
//   A following good packet with footer tlast=1 yields flags[2]=1.

Source files
------------

// File: rtl/spectrum_centroid_extractor.sv
// Frames sensor acquisition packets, unpacks the {d_acc,c_acc} payload and divides
// d_acc by c_acc into an unsigned Q10.FRAC_BITS centroid record held for the PS.
module spectrum_centroid_extractor #(
   parameter int          FRAC_BITS    = 8,
   parameter logic [31:0] HEADER_VALUE = 32'hAAAAAAAA,
   parameter logic [31:0] FOOTER_VALUE = 32'h55555555,
   localparam int         Q            = 10 + FRAC_BITS,
   localparam int         D            = 48 + FRAC_BITS
) (
   input  logic          master_clock,
   input  logic          resetn,
   input  logic [31:0]   data_tdata,
   input  logic          data_tvalid,
   input  logic          data_tlast,
   output logic          data_tready,
   output logic          result_valid,
   input  logic          result_ready,
   output logic [Q-1:0]  result_centroid,
   output logic [31:0]   result_timestamp,
   output logic [47:0]   result_c_acc,
   output logic [2:0]    result_flags,
   output logic [15:0]   frame_err_count,
   output logic [15:0]   drop_count,
   output logic [3:0]    dbg_state
);

   localparam int CW = $clog2(D + 1);

   typedef enum logic [3:0] {
      S_HUNT    = 4'd0,
      S_TS      = 4'd1,
      S_W0      = 4'd2,
      S_W1      = 4'd3,
      S_W2      = 4'd4,
      S_FTR     = 4'd5,
      S_DISCARD = 4'd6,
      S_DIVIDE  = 4'd7,
      S_HOLD    = 4'd8
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic            frame_err_s;
   logic            beat_s;
   logic            is_hdr_s;
   logic            is_ftr_s;
   logic            ld_ts_s;
   logic            ld_word_s;
   logic            ftr_ok_s;
   logic            div_step_s;
   logic            div_done_s;
   logic            release_s;
   logic            tready_next_s;
   logic            c_zero_s;

   logic [31:0]     ts_r;
   logic [47:0]     c_acc_r;
   logic [47:0]     d_acc_r;
   logic            last_r;
   logic [47:0]     rem_r;
   logic [D-1:0]    quo_r;
   logic [D-1:0]    dividend_r;
   logic [CW-1:0]   cnt_r;

   logic [48:0]     rem_shift_s;
   logic [48:0]     rem_diff_s;
   logic            q_bit_s;
   logic [47:0]     rem_next_s;
   logic [D-1:0]    quo_next_s;
   logic            sat_s;

   assign beat_s      = data_tvalid & data_tready;
   assign is_hdr_s    = (data_tdata == HEADER_VALUE);
   assign is_ftr_s    = (data_tdata == FOOTER_VALUE);
   assign c_zero_s    = (c_acc_r == 48'd0);
   assign dbg_state   = state_r;

   // State register
   always_ff @(posedge master_clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= S_HUNT;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and framing-error decode
   always_comb begin
      next_state_s = state_r;
      frame_err_s  = 1'b0;
      case (state_r)
         S_HUNT: begin
            if (beat_s && is_hdr_s) next_state_s = S_TS;
            else                    next_state_s = S_HUNT;
         end
         S_TS: begin
            if (beat_s) next_state_s = S_W0;
            else        next_state_s = S_TS;
         end
         S_W0, S_W1, S_W2: begin
            if (!beat_s) begin
               next_state_s = state_r;
            end else if (is_ftr_s) begin
               next_state_s = S_HUNT;
               frame_err_s  = 1'b1;
            end else if (is_hdr_s) begin
               next_state_s = S_TS;
               frame_err_s  = 1'b1;
            end else begin
               next_state_s = state_t'(state_r + 4'd1);
            end
         end
         S_FTR: begin
            if (!beat_s) begin
               next_state_s = S_FTR;
            end else if (is_ftr_s) begin
               next_state_s = S_DIVIDE;
            end else if (is_hdr_s) begin
               next_state_s = S_TS;
               frame_err_s  = 1'b1;
            end else begin
               next_state_s = S_DISCARD;
               frame_err_s  = 1'b1;
            end
         end
         S_DISCARD: begin
            if (beat_s && is_ftr_s)      next_state_s = S_HUNT;
            else if (beat_s && is_hdr_s) next_state_s = S_TS;
            else                         next_state_s = S_DISCARD;
         end
         S_DIVIDE: begin
            if (c_zero_s || (cnt_r == CW'(1'b1))) next_state_s = S_HOLD;
            else                                  next_state_s = S_DIVIDE;
         end
         S_HOLD: begin
            if (result_valid && result_ready) next_state_s = S_HUNT;
            else                              next_state_s = S_HOLD;
         end
         default: begin
            next_state_s = S_HUNT;
         end
      endcase
   end

   // Datapath control strobes derived from the current state
   always_comb begin
      ld_ts_s    = 1'b0;
      ld_word_s  = 1'b0;
      ftr_ok_s   = 1'b0;
      div_step_s = 1'b0;
      div_done_s = 1'b0;
      release_s  = 1'b0;
      case (state_r)
         S_TS:     ld_ts_s   = beat_s;
         S_W0, S_W1, S_W2:
                   ld_word_s = beat_s & ~is_hdr_s & ~is_ftr_s;
         S_FTR:    ftr_ok_s  = beat_s & is_ftr_s;
         S_DIVIDE: begin
            div_step_s = ~c_zero_s;
            div_done_s = c_zero_s | (cnt_r == CW'(1'b1));
         end
         S_HOLD:   release_s = result_valid & result_ready;
         default:  ld_ts_s   = 1'b0;
      endcase
      if ((next_state_s == S_DIVIDE) || (next_state_s == S_HOLD)) tready_next_s = 1'b0;
      else                                                      tready_next_s = 1'b1;
   end

   // One restoring-division step: remainder never exceeds c_acc, so 49 bits suffice
   always_comb begin
      rem_shift_s = {rem_r, dividend_r[D-1]};
      rem_diff_s  = rem_shift_s - {1'b0, c_acc_r};
      q_bit_s     = (rem_shift_s >= {1'b0, c_acc_r});
      if (q_bit_s) rem_next_s = rem_diff_s[47:0];
      else         rem_next_s = rem_shift_s[47:0];
      quo_next_s  = {quo_r[D-2:0], q_bit_s};
      sat_s       = |quo_next_s[D-1:Q];
   end

   // Packet capture and divider registers
   always_ff @(posedge master_clock or negedge resetn) begin
      if (!resetn) begin
         ts_r       <= 32'd0;
         c_acc_r    <= 48'd0;
         d_acc_r    <= 48'd0;
         last_r     <= 1'b0;
         rem_r      <= 48'd0;
         quo_r      <= {D{1'b0}};
         dividend_r <= {D{1'b0}};
         cnt_r      <= {CW{1'b0}};
      end else begin
         if (ld_ts_s) ts_r <= data_tdata;
         if (ld_word_s) begin
            case (state_r)
               S_W0: c_acc_r[31:0] <= data_tdata;
               S_W1: begin
                  d_acc_r[15:0]  <= data_tdata[31:16];
                  c_acc_r[47:32] <= data_tdata[15:0];
               end
               S_W2:    d_acc_r[47:16] <= data_tdata;
               default: d_acc_r        <= d_acc_r;
            endcase
         end
         if (ftr_ok_s) begin
            last_r     <= data_tlast;
            rem_r      <= 48'd0;
            quo_r      <= {D{1'b0}};
            dividend_r <= {d_acc_r, {FRAC_BITS{1'b0}}};
            cnt_r      <= CW'(D);
         end else if (div_step_s) begin
            rem_r      <= rem_next_s;
            quo_r      <= quo_next_s;
            dividend_r <= {dividend_r[D-2:0], 1'b0};
            cnt_r      <= cnt_r - CW'(1'b1);
         end
      end
   end

   // Result record, handshake, ready and saturating counters
   always_ff @(posedge master_clock or negedge resetn) begin
      if (!resetn) begin
         data_tready      <= 1'b0;
         result_valid     <= 1'b0;
         result_centroid  <= {Q{1'b0}};
         result_timestamp <= 32'd0;
         result_c_acc     <= 48'd0;
         result_flags     <= 3'd0;
         frame_err_count  <= 16'd0;
         drop_count       <= 16'd0;
      end else begin
         data_tready <= tready_next_s;
         if (div_done_s) begin
            result_valid     <= 1'b1;
            result_timestamp <= ts_r;
            result_c_acc     <= c_acc_r;
            if (c_zero_s) begin
               result_centroid <= {Q{1'b0}};
               result_flags    <= {last_r, 1'b0, 1'b1};
            end else if (sat_s) begin
               result_centroid <= {Q{1'b1}};
               result_flags    <= {last_r, 1'b1, 1'b0};
            end else begin
               result_centroid <= quo_next_s[Q-1:0];
               result_flags    <= {last_r, 1'b0, 1'b0};
            end
         end else if (release_s) begin
            result_valid <= 1'b0;
         end
         if (frame_err_s && (frame_err_count != 16'hFFFF)) frame_err_count <= frame_err_count + 16'd1;
         if (data_tvalid && !data_tready && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
   end

endmodule
